stream_inject: RTL and testbench
================================

# stream_inject

Stream injector: merges single-beat side-band messages into a packetized ready/valid stream, the additive counterpart of the stream filter, which removes beats. Injected beats are inserted only at packet boundaries, never inside an upstream packet, and are tagged so downstream logic can tell them apart. A burst limiter bounds how long injection can starve upstream. The block sits on datapath streams where control or status beats share a link with regular traffic, and has a registered output with one cycle of latency.

## Interface
- `DataWidth`, default 32: width of upstream, injection and output data.
- `MaxBurst`, default 4: maximum consecutive injected beats while an upstream beat waits; legal range 1..255.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  upstream beat valid.
- `ready_o`  out  1  upstream beat accepted.
- `data_i`  in  DataWidth  upstream data.
- `last_i`  in  1  upstream beat closes a packet.
- `inj_valid_i`  in  1  injection request valid.
- `inj_ready_o`  out  1  injection request accepted.
- `inj_data_i`  in  DataWidth  injection data.
- `valid_o`  out  1  output beat valid.
- `ready_i`  in  1  downstream ready.
- `data_o`  out  DataWidth  output data.
- `last_o`  out  1  output beat closes a packet.
- `inj_o`  out  1  output beat originated from the injection port.
- `inj_cnt_o`  out  32  count of injected beats; present only with the Configuration macro.

## Operation
- Output register holds `valid_o`, `data_o`, `last_o` and `inj_o`. Load enable is `ld = !valid_o || ready_i`.
- The state bit `in_pkt_q` has two states, BOUNDARY (0) and IN_PACKET (1).
  - BOUNDARY -> IN_PACKET when an upstream beat with `last_i=0` is accepted.
  - IN_PACKET -> BOUNDARY when an upstream beat with `last_i=1` is accepted.
- The burst counter `burst_q` is 8 bits.
  - Increments, saturating at MaxBurst, on every accepted injection.
  - Clears to 0 on every accepted upstream beat.
- Selection, evaluated only when `ld=1`:
  - IN_PACKET: upstream only; `inj_ready_o=0`.
  - BOUNDARY, injection wins if `inj_valid_i && (!valid_i || burst_q < MaxBurst)`.
  - Otherwise upstream wins if `valid_i`.
  - Otherwise the output register loads `valid_o=0`.
- `ready_o = ld && upstream selected`. `inj_ready_o = ld && injection selected`. At most one of the two is high in any cycle.
- An injected beat loads `data_o=inj_data_i`, `last_o=1`, `inj_o=1`.
- An upstream beat loads `data_o=data_i`, `last_o=last_i`, `inj_o=0`.
- Handshake rules:
  - `valid_o` and output data stay stable while `valid_o && !ready_i`.
  - `ready_o` and `inj_ready_o` may depend combinationally on `valid_i`, `inj_valid_i` and `ready_i`.
  - Upstream and injection sources must hold valid and data stable until accepted.
- Boundary conditions:
  - Simultaneous `valid_i` and `inj_valid_i` at a boundary with `burst_q=MaxBurst`: upstream wins and `burst_q` clears.
  - A single-beat upstream packet (`last_i=1`) leaves the state in BOUNDARY.
  - Injection with `valid_i=0` is unlimited; `burst_q` still saturates at MaxBurst.
  - Reset mid-packet returns to BOUNDARY. Any partially transferred packet is the system's responsibility.

## Timing
- Reset values: `valid_o=0`, `data_o=0`, `last_o=0`, `inj_o=0`, `in_pkt_q=0`, `burst_q=0`, `inj_cnt_o=0`.
- Latency: a beat accepted in cycle n appears on the output in cycle n+1.
- Throughput: 1 beat/cycle while `ready_i=1`.
- No combinational path from input data to output data.

## Configuration
- Macro: `STREAM_INJECT_STATS_EN`.
- Defined:
  - Port `inj_cnt_o` exists.
  - Increments by 1 on each accepted injection and wraps at 2^32.
  - Resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then `inj_valid_i=1`, `inj_data_i=0xA5`, `ready_i=1`, `valid_i=0`:
  - `inj_ready_o=1` in cycle 0.
  - Next cycle: `valid_o=1`, `data_o=0xA5`, `last_o=1`, `inj_o=1`.
- Upstream 3-beat packet D0,D1,D2 (`last_i` on D2) with `inj_valid_i=1` from cycle 1:
  - Output is D0,D1,D2 followed by the injected beat.
  - `inj_ready_o=0` until D2 is accepted.
- MaxBurst=2, `valid_i` and `inj_valid_i` held high, single-beat upstream packets:
  - Output pattern is I,I,U,I,I,U.
  - `burst_q` clears after each U.
- Downstream stall: hold `ready_i=0` for 5 cycles with a beat in the output register.
  - `data_o`, `last_o` and `inj_o` stay stable.
  - `ready_o=inj_ready_o=0`.
  - No beat is lost or duplicated after release.
- Reset asserted mid-packet after D0 (`last_i=0`), then deasserted with `inj_valid_i=1`:
  - All outputs return to 0.
  - The injection is accepted in the first cycle after reset.
- With `STREAM_INJECT_STATS_EN`: 7 accepted injections give `inj_cnt_o=7`. Upstream beats do not change `inj_cnt_o`.

Source files
------------

// File: rtl/stream_inject.sv
// +----------------------------------------------------------------------------+
// | stream_inject                                                              |
// | Inserts single-beat tagged messages into a packet stream at packet         |
// | boundaries, with a burst limit protecting waiting upstream traffic.        |
// | Optional: STREAM_INJECT_STATS_EN adds the inj_cnt_o injected-beat counter. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_inject #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxBurst  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 last_i,
  input  logic                 inj_valid_i,
  output logic                 inj_ready_o,
  input  logic [DataWidth-1:0] inj_data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 last_o,
  output logic                 inj_o
`ifdef STREAM_INJECT_STATS_EN
  ,
  output logic [31:0]          inj_cnt_o
`endif
);

  localparam logic [0:0] c_BOUNDARY  = 1'b0;
  localparam logic [0:0] c_IN_PACKET = 1'b1;
  localparam logic [7:0] c_MAX_BURST = 8'(MaxBurst);

  logic [0:0] r_in_pkt;
  logic [7:0] r_burst;
  logic       w_ld;
  logic       w_sel_inj;
  logic       w_sel_up;

  assign w_ld = !valid_o || ready_i;

  // The burst limit only matters when upstream is actually waiting.
  assign w_sel_inj = w_ld && (r_in_pkt == c_BOUNDARY) && inj_valid_i &&
                     (!valid_i || (r_burst < c_MAX_BURST));
  assign w_sel_up  = w_ld && valid_i && !w_sel_inj;

  assign ready_o     = w_sel_up;
  assign inj_ready_o = w_sel_inj;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      inj_o   <= 1'b0;
    end else if (w_ld) begin
      valid_o <= w_sel_inj || w_sel_up;
      if (w_sel_inj) begin
        data_o <= inj_data_i;
        last_o <= 1'b1;
        inj_o  <= 1'b1;
      end else if (w_sel_up) begin
        data_o <= data_i;
        last_o <= last_i;
        inj_o  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_in_pkt <= c_BOUNDARY;
      r_burst  <= 8'd0;
    end else begin
      if (w_sel_up) begin
        r_in_pkt <= last_i ? c_BOUNDARY : c_IN_PACKET;
        r_burst  <= 8'd0;
      end else if (w_sel_inj && (r_burst < c_MAX_BURST)) begin
        r_burst <= r_burst + 8'd1;
      end
    end
  end

`ifdef STREAM_INJECT_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inj_cnt_o <= 32'd0;
    end else if (w_sel_inj) begin
      inj_cnt_o <= inj_cnt_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_inject.sv
// +----------------------------------------------------------------------------+
// | tb_stream_inject                                                           |
// | Randomized bench for stream_inject with a cycle model and beat scoreboard. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stream_inject;

  localparam int DW = 32;
  localparam int MB = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          valid_i, ready_o, last_i;
  logic [DW-1:0] data_i;
  logic          inj_valid_i, inj_ready_o;
  logic [DW-1:0] inj_data_i;
  logic          valid_o, ready_i, last_o, inj_o;
  logic [DW-1:0] data_o;
`ifdef STREAM_INJECT_STATS_EN
  logic [31:0]   inj_cnt_o;
`endif

  stream_inject #(.DataWidth(DW), .MaxBurst(MB)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .last_i      (last_i),
    .inj_valid_i (inj_valid_i),
    .inj_ready_o (inj_ready_o),
    .inj_data_i  (inj_data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .last_o      (last_o),
    .inj_o       (inj_o)
`ifdef STREAM_INJECT_STATS_EN
    ,
    .inj_cnt_o   (inj_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Sources and scoreboard
  logic [32:0] up_q[$];
  logic [31:0] inj_q[$];
  logic [33:0] exp_q[$];
  bit          obs_inj[$];
  bit          up_on, inj_on;
  int          up_rate, inj_rate, rdy_rate;

  // Reference state, kept as plain numbers
  bit          m_valid, m_in_pkt;
  int          m_burst;
  int unsigned m_cnt;

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle();
    bit m_ld, s_inj, s_up, acc_up, acc_inj;
    logic [33:0] e;
    if (!up_on && up_q.size() > 0 && $urandom_range(99) < up_rate) up_on = 1;
    if (!inj_on && inj_q.size() > 0 && $urandom_range(99) < inj_rate) inj_on = 1;
    valid_i = up_on;
    {last_i, data_i} = up_on ? up_q[0] : {1'b0, $urandom()};
    inj_valid_i = inj_on;
    inj_data_i  = inj_on ? inj_q[0] : $urandom();
    ready_i     = ($urandom_range(99) < rdy_rate);
    #2;
    m_ld  = !m_valid || ready_i;
    s_inj = m_ld && !m_in_pkt && inj_valid_i && (!valid_i || m_burst < MB);
    s_up  = m_ld && valid_i && !s_inj;
    check("ready_o", ready_o, s_up);
    check("inj_ready_o", inj_ready_o, s_inj);
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("out_beat", {inj_o, last_o, data_o}, e);
        obs_inj.push_back(inj_o);
      end
    end
    acc_up  = ready_o;
    acc_inj = inj_ready_o;
    @(posedge clk_i);
    if (m_ld) begin
      m_valid = s_inj || s_up;
      if (s_inj) begin
        exp_q.push_back({1'b1, 1'b1, inj_data_i});
        m_cnt++;
        if (m_burst < MB) m_burst++;
      end else if (s_up) begin
        exp_q.push_back({1'b0, last_i, data_i});
        m_in_pkt = !last_i;
        m_burst  = 0;
      end
    end
    if (up_on && acc_up) begin void'(up_q.pop_front()); up_on = 0; end
    if (inj_on && acc_inj) begin void'(inj_q.pop_front()); inj_on = 0; end
    #1;
    check("valid_o", valid_o, m_valid);
`ifdef STREAM_INJECT_STATS_EN
    check("inj_cnt_o", inj_cnt_o, m_cnt);
`endif
  endtask

  task automatic push_pkt(input int len);
    for (int k = 0; k < len; k++) up_q.push_back({(k == len - 1), $urandom()});
  endtask

  task automatic drain();
    up_rate = 100; inj_rate = 100; rdy_rate = 100;
    for (int k = 0; k < 200 && (up_q.size() > 0 || inj_q.size() > 0 || m_valid); k++) cycle();
    check("drained", up_q.size() + inj_q.size() + exp_q.size() + int'(m_valid), 0);
  endtask

  task automatic model_reset();
    m_valid = 0; m_in_pkt = 0; m_burst = 0; m_cnt = 0;
    exp_q.delete(); up_q.delete(); inj_q.delete();
    up_on = 0; inj_on = 0;
    valid_i = 0; inj_valid_i = 0; last_i = 0; data_i = '0; inj_data_i = '0;
  endtask

  initial begin
    bit pat [6];
    logic [DW-1:0] sd;
    logic sl, si;
    int unsigned c0;
    rst_ni = 1'b0; ready_i = 1'b0;
    model_reset();
    #3;
    check("rst_valid_o", valid_o, 0);
    check("rst_data_o", data_o, 0);
    check("rst_last_o", last_o, 0);
    check("rst_inj_o", inj_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Lone injection with idle upstream
    inj_q.push_back(32'hA5);
    up_rate = 100; inj_rate = 100; rdy_rate = 100;
    cycle();
    check("first_inj_data", data_o, 32'hA5);
    check("first_inj_last", last_o, 1);
    check("first_inj_tag", inj_o, 1);
    drain();

    // Injection arriving mid-packet waits for the boundary
    obs_inj.delete();
    push_pkt(3);
    cycle();
    inj_q.push_back($urandom());
    drain();
    check("pkt_order_n", obs_inj.size(), 4);
    for (int k = 0; k < 4 && k < obs_inj.size(); k++) check("pkt_order", obs_inj[k], (k == 3));

    // Burst limit with both sources saturated
    push_pkt(1);
    drain();
    obs_inj.delete();
    push_pkt(1); push_pkt(1);
    repeat (4) inj_q.push_back($urandom());
    drain();
    pat = '{1, 1, 0, 1, 1, 0};
    check("burst_n", obs_inj.size(), 6);
    for (int k = 0; k < 6 && k < obs_inj.size(); k++) check("burst_pattern", obs_inj[k], pat[k]);

    // Downstream stall with a beat held in the output register
    inj_q.push_back($urandom());
    cycle();
    push_pkt(2);
    sd = data_o; sl = last_o; si = inj_o;
    rdy_rate = 0;
    repeat (5) begin
      cycle();
      check("stall_data", data_o, sd);
      check("stall_last", last_o, sl);
      check("stall_inj", inj_o, si);
    end
    drain();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) begin
        up_rate  = $urandom_range(100, 20);
        inj_rate = $urandom_range(100, 10);
        rdy_rate = $urandom_range(100, 30);
      end
      if (up_q.size() < 4) push_pkt($urandom_range(4, 1));
      if (inj_q.size() < 2 && $urandom_range(3) == 0) inj_q.push_back($urandom());
      cycle();
    end
    drain();

`ifdef STREAM_INJECT_STATS_EN
    c0 = inj_cnt_o;
    repeat (7) inj_q.push_back($urandom());
    push_pkt(2); push_pkt(1);
    drain();
    check("cnt_seven", inj_cnt_o - c0, 7);
`else
    c0 = 0;
`endif

    // Reset in the middle of a packet
    up_q.push_back({1'b0, 32'hD0D0_0000});
    cycle();
    check("mid_pkt_loaded", valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_valid_o", valid_o, 0);
    check("mid_rst_data_o", data_o, 0);
    check("mid_rst_last_o", last_o, 0);
    check("mid_rst_inj_o", inj_o, 0);
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    inj_q.push_back(32'h5A);
    push_pkt(1);
    up_rate = 100; inj_rate = 100; rdy_rate = 100;
    cycle();
    check("post_rst_inj", {valid_o, inj_o, data_o}, {1'b1, 1'b1, 32'h5A});
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
